// File: rtl/priority_encoder_74148_irq.sv
// priority_encoder_74148_irq
//
// Clocked 8-line to 3-line interrupt encoder. It behaves like the 74148 (K555IV1),
// with request latching and an acknowledge handshake added.
// Active-low request lines are captured into a pending register. The pending register
// is then masked, and the highest-priority surviving request is presented on active-low
// 74148-style pins. Once a vector is presented it stays frozen until it is acknowledged.
// After the acknowledge, one holdoff cycle runs before the next vector can be presented.
//
// Parameters
//   LEVEL_MODE  0: a falling edge on req_n[i] sets pending[i]
//               1: req_n[i] low sets pending[i] on every cycle
//
// Ports
//   C        in   1  clock; all logic is on posedge
//   R        in   1  synchronous active-high reset
//   req_n    in   8  request lines I0..I7, active-low, I7 has the highest priority
//   mask_we  in   1  write strobe for the mask register
//   mask_d   in   8  mask data, 1 = request masked
//   ack      in   1  one-cycle acknowledge of the presented vector
//   int_n    out  1  registered interrupt, active-low
//   a_n      out  3  registered vector A2..A0, active-low (I7 -> 000, I0 -> 111)
//   gs_n     out  1  group select, low while any unmasked pending bit is set
//   pending  out  8  pending request register

module priority_encoder_74148_irq #(
  parameter bit LEVEL_MODE = 1'b0
) (
  input  logic       C,
  input  logic       R,
  input  logic [7:0] req_n,
  input  logic       mask_we,
  input  logic [7:0] mask_d,
  input  logic       ack,
  output logic       int_n,
  output logic [2:0] a_n,
  output logic       gs_n,
  output logic [7:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] mask;
  logic [7:0] req_prev;
  logic [2:0] code;
  logic [2:0] code_nxt;
  logic [2:0] a_n_nxt;
  logic       int_n_nxt;
  logic [7:0] set_vec;
  logic [7:0] clr_vec;
  logic [7:0] active;
  logic [2:0] hi_idx;

  // Capture the new requests. In edge mode a bit sets only on a high-to-low transition
  // between two samples. After reset, req_prev is all ones, so a line that is already
  // low when reset is released counts as a fresh falling edge.
  always_comb begin
    if (LEVEL_MODE)
      set_vec = ~req_n;
    else
      set_vec = req_prev & ~req_n;
  end

  // The mask only affects encoding and gs_n. Masked requests still latch into pending.
  // gs_n is decoded from registers only, so no input reaches an output combinationally.
  always_comb begin
    active = pending & ~mask;
    gs_n   = ~|active;
  end

  // Find the highest set index of active. The loop runs upward, so the last hit wins.
  // This gives I7 priority over all the lower lines.
  always_comb begin
    hi_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (active[i])
        hi_idx = 3'(i);
    end
  end

  // Next-state logic. HOLDOFF always lasts exactly one cycle. This guarantees an idle
  // cycle between two vectors, so the acknowledging side sees int_n deasserted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|active) state_nxt = ASSERT;
      ASSERT:  if (ack)     state_nxt = HOLDOFF;
      HOLDOFF: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and clear logic.
  // In ASSERT, code and a_n are held, even if a higher request arrives or the mask changes.
  // An ack is honoured only in ASSERT, and it clears only the bit that was presented.
  always_comb begin
    code_nxt  = code;
    a_n_nxt   = a_n;
    int_n_nxt = int_n;
    clr_vec   = 8'h00;
    case (state)
      IDLE: begin
        if (|active) begin
          code_nxt  = hi_idx;
          a_n_nxt   = ~hi_idx;
          int_n_nxt = 1'b0;
        end
      end
      ASSERT: begin
        if (ack) begin
          clr_vec   = 8'h01 << code;
          int_n_nxt = 1'b1;
          a_n_nxt   = 3'b111;
        end
      end
      HOLDOFF: begin
        int_n_nxt = 1'b1;
        a_n_nxt   = 3'b111;
      end
      default: begin
        int_n_nxt = 1'b1;
        a_n_nxt   = 3'b111;
      end
    endcase
  end

  // State and datapath registers.
  // A set and a clear on the same bit in the same cycle leave the bit set, so a request
  // that repeats while its ack is in flight is not lost.
  always_ff @(posedge C) begin
    if (R) begin
      state    <= IDLE;
      pending  <= 8'h00;
      mask     <= 8'h00;
      req_prev <= 8'hFF;
      code     <= 3'd0;
      a_n      <= 3'b111;
      int_n    <= 1'b1;
    end else begin
      state    <= state_nxt;
      pending  <= (pending & ~clr_vec) | set_vec;
      req_prev <= req_n;
      code     <= code_nxt;
      a_n      <= a_n_nxt;
      int_n    <= int_n_nxt;
      if (mask_we)
        mask <= mask_d;
    end
  end

endmodule

// File: tb/tb_priority_encoder_74148_irq.sv
// tb_priority_encoder_74148_irq
//
// Directed bench for priority_encoder_74148_irq, edge-capture mode.
// Inputs change 1 time unit after a rising edge. Outputs are observed at that same
// point, so each check sees the register values produced by the edge just taken.

module tb_priority_encoder_74148_irq;

  logic       C;
  logic       R;
  logic [7:0] req_n;
  logic       mask_we;
  logic [7:0] mask_d;
  logic       ack;
  logic       int_n;
  logic [2:0] a_n;
  logic       gs_n;
  logic [7:0] pending;

  int compared;
  int mismatched;

  priority_encoder_74148_irq #(.LEVEL_MODE(1'b0)) dut (
    .C       (C),
    .R       (R),
    .req_n   (req_n),
    .mask_we (mask_we),
    .mask_d  (mask_d),
    .ack     (ack),
    .int_n   (int_n),
    .a_n     (a_n),
    .gs_n    (gs_n),
    .pending (pending)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge C);
    #1;
  endtask

  // Drive all inputs at once. Called only just after an edge.
  task automatic apply_stimulus(input logic r, input logic [7:0] rq, input logic we,
                                input logic [7:0] md, input logic a);
    R       = r;
    req_n   = rq;
    mask_we = we;
    mask_d  = md;
    ack     = a;
  endtask

  // Compare one observed value against the hand-computed value.
  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Check the complete visible state in one call.
  task automatic check_all(input string tag, input logic e_int_n, input logic [2:0] e_a_n,
                           input logic e_gs_n, input logic [7:0] e_pending);
    check_output({tag, ".int_n"},   {7'd0, int_n}, {7'd0, e_int_n});
    check_output({tag, ".a_n"},     {5'd0, a_n},   {5'd0, e_a_n});
    check_output({tag, ".gs_n"},    {7'd0, gs_n},  {7'd0, e_gs_n});
    check_output({tag, ".pending"}, pending,       e_pending);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Reset held for two edges while every request line is low
    apply_stimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    check_all("reset", 1'b1, 3'b111, 1'b1, 8'h00);
    apply_stimulus(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0);
    tick();
    check_all("reset_release", 1'b1, 3'b111, 1'b1, 8'h00);

    // Single request on I5
    apply_stimulus(1'b0, 8'hDF, 1'b0, 8'h00, 1'b0);
    tick();
    check_all("single_capture", 1'b1, 3'b111, 1'b0, 8'h20);
    tick();
    check_all("single_present", 1'b0, 3'b010, 1'b0, 8'h20);
    apply_stimulus(1'b0, 8'hDF, 1'b0, 8'h00, 1'b1);
    tick();
    check_all("single_ack", 1'b1, 3'b111, 1'b1, 8'h00);
    apply_stimulus(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    check_all("single_idle", 1'b1, 3'b111, 1'b1, 8'h00);

    // I2 and I6 arrive together; I6 is presented first, then I2
    apply_stimulus(1'b0, 8'hBB, 1'b0, 8'h00, 1'b0);
    tick();
    check_output("prio_capture.pending", pending, 8'h44);
    tick();
    check_all("prio_first", 1'b0, 3'b001, 1'b0, 8'h44);
    apply_stimulus(1'b0, 8'hFF, 1'b0, 8'h00, 1'b1);
    tick();
    check_all("prio_ack", 1'b1, 3'b111, 1'b0, 8'h04);
    apply_stimulus(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0);
    tick();
    check_output("prio_holdoff.int_n", {7'd0, int_n}, 8'h01);
    tick();
    check_all("prio_second", 1'b0, 3'b101, 1'b0, 8'h04);
    apply_stimulus(1'b0, 8'hFF, 1'b0, 8'h00, 1'b1);
    tick();
    apply_stimulus(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    check_all("prio_done", 1'b1, 3'b111, 1'b1, 8'h00);

    // The I1 vector stays frozen while I7 arrives during ASSERT
    apply_stimulus(1'b0, 8'hFD, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    check_all("freeze_i1", 1'b0, 3'b110, 1'b0, 8'h02);
    apply_stimulus(1'b0, 8'h7D, 1'b0, 8'h00, 1'b0);
    tick();
    check_all("freeze_i7_arrives", 1'b0, 3'b110, 1'b0, 8'h82);
    tick();
    check_output("freeze_hold.a_n", {5'd0, a_n}, 8'h06);
    apply_stimulus(1'b0, 8'hFF, 1'b0, 8'h00, 1'b1);
    tick();
    check_all("freeze_ack", 1'b1, 3'b111, 1'b0, 8'h80);
    apply_stimulus(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    check_all("freeze_i7", 1'b0, 3'b000, 1'b0, 8'h80);
    apply_stimulus(1'b0, 8'hFF, 1'b0, 8'h00, 1'b1);
    tick();
    apply_stimulus(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    check_all("freeze_done", 1'b1, 3'b111, 1'b1, 8'h00);

    // A masked I7 latches into pending but does not interrupt until it is unmasked
    apply_stimulus(1'b0, 8'hFF, 1'b1, 8'h80, 1'b0);
    tick();
    apply_stimulus(1'b0, 8'h7F, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    check_all("mask_hidden", 1'b1, 3'b111, 1'b1, 8'h80);
    apply_stimulus(1'b0, 8'hFF, 1'b1, 8'h00, 1'b0);
    tick();
    check_all("mask_cleared", 1'b1, 3'b111, 1'b0, 8'h80);
    apply_stimulus(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0);
    tick();
    check_all("mask_present", 1'b0, 3'b000, 1'b0, 8'h80);
    apply_stimulus(1'b0, 8'hFF, 1'b0, 8'h00, 1'b1);
    tick();
    apply_stimulus(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    check_all("mask_done", 1'b1, 3'b111, 1'b1, 8'h00);

    // A new I3 edge in the same cycle as the ack of I3 keeps the bit pending
    apply_stimulus(1'b0, 8'hF7, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    check_all("collide_present", 1'b0, 3'b100, 1'b0, 8'h08);
    apply_stimulus(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0);
    tick();
    apply_stimulus(1'b0, 8'hF7, 1'b0, 8'h00, 1'b1);
    tick();
    check_all("collide_ack", 1'b1, 3'b111, 1'b0, 8'h08);
    apply_stimulus(1'b0, 8'hF7, 1'b0, 8'h00, 1'b0);
    tick();
    check_output("collide_holdoff.int_n", {7'd0, int_n}, 8'h01);
    tick();
    check_all("collide_again", 1'b0, 3'b100, 1'b0, 8'h08);

    // Reset in the middle of ASSERT
    apply_stimulus(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0);
    tick();
    check_all("mid_reset", 1'b1, 3'b111, 1'b1, 8'h00);
    apply_stimulus(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    check_all("post_reset", 1'b1, 3'b111, 1'b1, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
